// File: rtl/mcp_ctrl_fsm.sv
// ============================================================================
// Module   : mcp_ctrl_fsm
// Purpose  : Multicycle MIPS main control FSM; sequences fetch/decode/execute/
//            memory/writeback and drives every datapath enable and mux select.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mcp_ctrl_fsm #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i6,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  output logic [1:0] alt_ctrl_o2,
  output logic       funct_sel_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o2,
  output logic [1:0] pc_src_o2,
  output logic       pc_en_o,
  output logic       iord_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       illegal_o,
  output logic [3:0] state_o4
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q;
  state_t state_d;
  logic   w_rdy;

  assign w_rdy    = MEM_WAIT_EN ? mem_ready_i : 1'b1;
  assign state_o4 = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = w_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_i6)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op_i6 == OP_LW)      state_d = S_MEMREAD;
        else if (op_i6 == OP_SW) state_d = S_MEMWRITE;
        else                     state_d = S_FETCH;
      end
      S_MEMREAD:  state_d = w_rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = w_rdy ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEX:   state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    alt_ctrl_o2  = 2'b00;
    funct_sel_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o2 = 2'b00;
    pc_src_o2    = 2'b00;
    pc_en_o      = 1'b0;
    iord_o       = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    illegal_o    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b_o2 = 2'b01;
        ir_write_o   = w_rdy;
        pc_en_o      = w_rdy;
      end
      S_DECODE: begin
        // ALU precomputes PC + (imm<<2) so BRANCH can take it from ALUOut.
        alu_src_b_o2 = 2'b11;
        case (op_i6)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_o = 1'b0;
          default:                                       illegal_o = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o2 = 2'b10;
      end
      S_MEMREAD:  iord_o = 1'b1;
      S_MEMWB: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
      end
      S_MEMWRITE: begin
        iord_o      = 1'b1;
        mem_write_o = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a_o = 1'b1;
        funct_sel_o = 1'b1;
        alt_ctrl_o2 = 2'b10;
      end
      S_ALUWB: begin
        reg_dst_o   = 1'b1;
        reg_write_o = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alt_ctrl_o2 = 2'b01;
        pc_src_o2   = 2'b01;
        pc_en_o     = zero_i;
      end
      S_ADDIEX: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o2 = 2'b10;
      end
      S_ADDIWB:   reg_write_o = 1'b1;
      S_JUMP: begin
        pc_src_o2 = 2'b10;
        pc_en_o   = 1'b1;
      end
      default: ;
    endcase
    // Reset suppresses every side effect so an abandoned instruction leaves no trace.
    if (rst_i) begin
      pc_en_o     = 1'b0;
      ir_write_o  = 1'b0;
      mem_write_o = 1'b0;
      reg_write_o = 1'b0;
      illegal_o   = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mcp_ctrl_fsm.sv
// Randomized bench for mcp_ctrl_fsm: per-instruction expected cycle traces built
// from the instruction's phase list and memory wait counts.
`default_nettype none

module tb_mcp_ctrl_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op  = 6'd0;
  logic       rdy = 1'b1;
  logic       zero = 1'b0;

  logic [1:0] alt, srcb, pcsrc;
  logic       fsel, srca, pcen, iord, mw, irw, rdst, m2r, rw, ill;
  logic [3:0] st;

  logic [1:0] n_alt, n_srcb, n_pcsrc;
  logic       n_fsel, n_srca, n_pcen, n_iord, n_mw, n_irw, n_rdst, n_m2r, n_rw, n_ill;
  logic [3:0] n_st;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mcp_ctrl_fsm #(.MEM_WAIT_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .op_i6(op), .mem_ready_i(rdy), .zero_i(zero),
    .alt_ctrl_o2(alt), .funct_sel_o(fsel), .alu_src_a_o(srca), .alu_src_b_o2(srcb),
    .pc_src_o2(pcsrc), .pc_en_o(pcen), .iord_o(iord), .mem_write_o(mw),
    .ir_write_o(irw), .reg_dst_o(rdst), .mem_to_reg_o(m2r), .reg_write_o(rw),
    .illegal_o(ill), .state_o4(st)
  );

  mcp_ctrl_fsm #(.MEM_WAIT_EN(1'b0)) dut_nw (
    .clk_i(clk), .rst_i(rst), .op_i6(op), .mem_ready_i(rdy), .zero_i(zero),
    .alt_ctrl_o2(n_alt), .funct_sel_o(n_fsel), .alu_src_a_o(n_srca), .alu_src_b_o2(n_srcb),
    .pc_src_o2(n_pcsrc), .pc_en_o(n_pcen), .iord_o(n_iord), .mem_write_o(n_mw),
    .ir_write_o(n_irw), .reg_dst_o(n_rdst), .mem_to_reg_o(n_m2r), .reg_write_o(n_rw),
    .illegal_o(n_ill), .state_o4(n_st)
  );

  logic [19:0] act;
  assign act = {st, alt, fsel, srca, srcb, pcsrc, pcen, iord, mw, irw, rdst, m2r, rw, ill};

  // Packed expectation: {state, alt, fsel, srca, srcb, pcsrc, pcen, iord, mw, irw, rdst, m2r, rw, ill}
  function automatic logic [19:0] ev(input int s, input logic [1:0] a, input logic fs, input logic sa,
                                     input logic [1:0] sb, input logic [1:0] ps, input logic pe,
                                     input logic io, input logic w, input logic iw, input logic rd,
                                     input logic mr, input logic r, input logic il);
    logic [3:0] s4;
    s4 = s[3:0];
    return {s4, a, fs, sa, sb, ps, pe, io, w, iw, rd, mr, r, il};
  endfunction

  function automatic logic legal(input logic [5:0] o);
    return (o == OP_R) || (o == OP_LW) || (o == OP_SW) || (o == OP_BEQ) || (o == OP_ADDI) || (o == OP_J);
  endfunction

  task automatic cyc(input logic [19:0] exp, input logic r, input logic z, input logic [5:0] o,
                     input string nm);
    rdy = r; zero = z; op = o;
    @(negedge clk);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
    @(posedge clk); #1;
  endtask

  // One instruction from FETCH back to the next FETCH; wf/wm = memory wait cycles.
  task automatic run_instr(input logic [5:0] o, input int wf, input int wm, input logic zr);
    for (int i = 0; i < wf; i++)
      cyc(ev(0, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'($urandom), 6'($urandom), "fetch_wait");
    cyc(ev(0, 2'b00, 0, 0, 2'b01, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0), 1'b1, 1'($urandom), 6'($urandom), "fetch");
    cyc(ev(1, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, !legal(o)), 1'($urandom), 1'($urandom), o, "decode");
    if (o == OP_LW || o == OP_SW)
      cyc(ev(2, 2'b00, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom), 1'($urandom), o, "memadr");
    if (o == OP_LW) begin
      for (int i = 0; i <= wm; i++)
        cyc(ev(3, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0), i == wm, 1'($urandom), 6'($urandom), "memread");
      cyc(ev(4, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0), 1'($urandom), 1'($urandom), 6'($urandom), "memwb");
    end else if (o == OP_SW) begin
      for (int i = 0; i <= wm; i++)
        cyc(ev(5, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0), i == wm, 1'($urandom), 6'($urandom), "memwrite");
    end else if (o == OP_R) begin
      cyc(ev(6, 2'b10, 1, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom), 1'($urandom), 6'($urandom), "execute");
      cyc(ev(7, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0), 1'($urandom), 1'($urandom), 6'($urandom), "aluwb");
    end else if (o == OP_BEQ) begin
      cyc(ev(8, 2'b01, 0, 1, 2'b00, 2'b01, zr, 0, 0, 0, 0, 0, 0, 0), 1'($urandom), zr, 6'($urandom), "branch");
    end else if (o == OP_ADDI) begin
      cyc(ev(9, 2'b00, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom), 1'($urandom), 6'($urandom), "addiex");
      cyc(ev(10, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0), 1'($urandom), 1'($urandom), 6'($urandom), "addiwb");
    end else if (o == OP_J) begin
      cyc(ev(11, 2'b00, 0, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0), 1'($urandom), 1'($urandom), 6'($urandom), "jump");
    end
  endtask

  task automatic check_quiet(input string nm, input logic [3:0] exp_st);
    @(negedge clk);
    checks++;
    if ({pcen, irw, mw, rw, ill} !== 5'b0 || st !== exp_st) begin
      failures++;
      $display("FAIL %s: got state=%0d en=%b expected state=%0d en=00000", nm, st, {pcen, irw, mw, rw, ill}, exp_st);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; op = OP_LW;
    @(posedge clk); #1;
    check_quiet("reset_hold", 4'd0);
    rst = 1'b0;
    // Get stuck in MEMREAD, then reset mid-instruction.
    cyc(ev(0, 2'b00, 0, 0, 2'b01, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0), 1'b1, 1'b0, OP_LW, "pre_fetch");
    cyc(ev(1, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, OP_LW, "pre_decode");
    cyc(ev(2, 2'b00, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, OP_LW, "pre_memadr");
    cyc(ev(3, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, OP_LW, "pre_memread");
    rst = 1'b1; rdy = 1'b0;
    check_quiet("reset_in_memread", 4'd3);
    rdy = 1'b1;
    check_quiet("reset_to_fetch", 4'd0);
    rst = 1'b0;
    run_instr(OP_J, 0, 0, 1'b0);
  endtask

  task automatic test_rtype();  run_instr(OP_R, 0, 0, 1'b0); endtask
  task automatic test_lw_wait(); run_instr(OP_LW, 0, 3, 1'b0); endtask
  task automatic test_beq();    run_instr(OP_BEQ, 0, 0, 1'b1); run_instr(OP_BEQ, 1, 0, 1'b0); endtask
  task automatic test_sw_wait(); run_instr(OP_SW, 0, 2, 1'b0); endtask
  task automatic test_illegal(); run_instr(6'b111111, 0, 0, 1'b0); run_instr(OP_ADDI, 2, 0, 1'b0); endtask

  task automatic test_random();
    logic [5:0] ops [6];
    logic [5:0] o;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    for (int n = 0; n < 40; n++) begin
      int k;
      k = int'($urandom_range(0, 6));
      if (k < 6) o = ops[k];
      else begin
        o = 6'($urandom);
        while (legal(o)) o = 6'($urandom);
      end
      run_instr(o, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    end
  endtask

  task automatic nw_step(input logic [3:0] es, input logic eiw, input logic emw, input logic [5:0] o,
                         input string nm);
    rdy = 1'b0; op = o;
    @(negedge clk);
    checks++;
    if (n_st !== es || n_irw !== eiw || n_pcen !== eiw || n_mw !== emw) begin
      failures++;
      $display("FAIL %s: got state=%0d irw=%b pcen=%b mw=%b expected state=%0d irw=%b pcen=%b mw=%b",
               nm, n_st, n_irw, n_pcen, n_mw, es, eiw, eiw, emw);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_nowait();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nw_step(4'd0, 1'b1, 1'b0, OP_LW, "nw_fetch");
    nw_step(4'd1, 1'b0, 1'b0, OP_LW, "nw_decode");
    nw_step(4'd2, 1'b0, 1'b0, OP_LW, "nw_memadr");
    nw_step(4'd3, 1'b0, 1'b0, OP_LW, "nw_memread");
    nw_step(4'd4, 1'b0, 1'b0, OP_LW, "nw_memwb");
    nw_step(4'd0, 1'b1, 1'b0, OP_SW, "nw_fetch2");
    nw_step(4'd1, 1'b0, 1'b0, OP_SW, "nw_decode2");
    nw_step(4'd2, 1'b0, 1'b0, OP_SW, "nw_memadr2");
    nw_step(4'd5, 1'b0, 1'b1, OP_SW, "nw_memwrite");
    nw_step(4'd0, 1'b1, 1'b0, OP_SW, "nw_fetch3");
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_sw_wait();
    test_illegal();
    test_random();
    test_nowait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
